// File: rtl/qcore_reg_dbg_if.sv
// rtl/qcore_reg_dbg_if.sv - host request/response bus of the register debug bridge
// Purpose: groups the host-side handshake of qcore_reg_dbg.
// Signals (suffixes are relative to the bridge):
//   req_i    host request, held until ack_o
//   op_i     0 = read, 1 = write
//   addr_i   7-bit core register address, [6:5] page
//   len_i    read burst length minus 1
//   wdt_i    write data
//   ack_o    transaction complete, held until req_i falls
//   err_o    rejected or timed out, valid with ack_o
//   rd_dt_o  read data
//   rd_vld_o one-cycle pulse per read word
interface qcore_reg_dbg_if #(
  parameter int LEN_W = 4
);
  logic             req_i;
  logic             op_i;
  logic [6:0]       addr_i;
  logic [LEN_W-1:0] len_i;
  logic [31:0]      wdt_i;
  logic             ack_o;
  logic             err_o;
  logic [31:0]      rd_dt_o;
  logic             rd_vld_o;

  modport master (
    output req_i, op_i, addr_i, len_i, wdt_i,
    input  ack_o, err_o, rd_dt_o, rd_vld_o
  );

  modport slave (
    input  req_i, op_i, addr_i, len_i, wdt_i,
    output ack_o, err_o, rd_dt_o, rd_vld_o
  );
endinterface

// File: rtl/qcore_reg_dbg.sv
// rtl/qcore_reg_dbg.sv - debug access bridge for the qick core register bank
// Purpose: stalls the core, takes the bank write port and read port D0, and
// performs a single write or a burst read on behalf of an external host.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   host                 host request/response bus (slave side)
//   stall_req_o          ask the core to drain and freeze
//   stall_ack_i          core drained, bank ports free
//   own_o                bridge owns the bank ports (core mux select)
//   bank_we_o, bank_w_addr_o, bank_w_dt_o   bank write port
//   bank_rs_addr_o, bank_rs_dt_i            bank read port D0 (combinational data)
module qcore_reg_dbg #(
  parameter int TOUT_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  qcore_reg_dbg_if.slave       host,
  output logic                 stall_req_o,
  input  logic                 stall_ack_i,
  output logic                 own_o,
  output logic                 bank_we_o,
  output logic [6:0]           bank_w_addr_o,
  output logic [31:0]          bank_w_dt_o,
  output logic [6:0]           bank_rs_addr_o,
  input  logic [31:0]          bank_rs_dt_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STALL,
    S_WR,
    S_RD,
    S_DONE
  } state_e;

  state_e             state_q;

  // Captured request
  logic               op_q;
  logic [6:0]         addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [31:0]        wdt_q;

  logic [LEN_W-1:0]   beat_q;
  logic [TOUT_W-1:0]  tout_q;
  logic [TOUT_W-1:0]  tout_d;

  // Registered outputs
  logic               ack_q;
  logic               err_q;
  logic [31:0]        rd_dt_q;
  logic               rd_vld_q;
  logic               stall_q;
  logic               own_q;
  logic               we_q;
  logic [6:0]         w_addr_q;
  logic [31:0]        w_dt_q;
  logic [6:0]         rs_addr_q;

  logic               illegal;

  assign tout_d = tout_q + TOUT_W'(1);

  // Page 11 is reserved. SFR writes are only allowed to the writable
  // registers; indices 0 and 3..11 are read-only status.
  assign illegal = (addr_q[6:5] == 2'b11) ||
                   (op_q && (addr_q[6:5] == 2'b10) &&
                    ((addr_q[5:0] == 6'd0) ||
                     ((addr_q[5:0] >= 6'd3) && (addr_q[5:0] <= 6'd11))));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wdt_q     <= '0;
      beat_q    <= '0;
      tout_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_dt_q   <= '0;
      rd_vld_q  <= 1'b0;
      stall_q   <= 1'b0;
      own_q     <= 1'b0;
      we_q      <= 1'b0;
      w_addr_q  <= '0;
      w_dt_q    <= '0;
      rs_addr_q <= '0;
    end else begin
      rd_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host.req_i) begin
            op_q    <= host.op_i;
            addr_q  <= host.addr_i;
            len_q   <= host.len_i;
            wdt_q   <= host.wdt_i;
            beat_q  <= '0;
            tout_q  <= '0;
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (illegal) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            stall_q <= 1'b1;
            state_q <= S_STALL;
          end
        end

        S_STALL: begin
          if (stall_ack_i) begin
            own_q <= 1'b1;
            if (op_q) begin
              we_q     <= 1'b1;
              w_addr_q <= addr_q;
              w_dt_q   <= wdt_q;
              state_q  <= S_WR;
            end else begin
              rs_addr_q <= addr_q;
              state_q   <= S_RD;
            end
          end else if (tout_d == '1) begin
            // Core never drained: give up without ever owning the bank.
            stall_q <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tout_q <= tout_d;
          end
        end

        S_WR: begin
          we_q     <= 1'b0;
          w_addr_q <= '0;
          w_dt_q   <= '0;
          ack_q    <= 1'b1;
          state_q  <= S_DONE;
        end

        S_RD: begin
          rd_dt_q  <= bank_rs_dt_i;
          rd_vld_q <= 1'b1;
          if (beat_q == len_q) begin
            // Last word: its rd_vld pulse and ack_o rise together.
            rs_addr_q <= '0;
            ack_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            beat_q <= beat_q + LEN_W'(1);
            // Index walks addr[5:0] modulo 64; bit 6 is held.
            rs_addr_q <= {rs_addr_q[6], rs_addr_q[5:0] + 6'd1};
          end
        end

        S_DONE: begin
          if (!host.req_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            own_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host.ack_o    = ack_q;
  assign host.err_o    = err_q;
  assign host.rd_dt_o  = rd_dt_q;
  assign host.rd_vld_o = rd_vld_q;
  assign stall_req_o   = stall_q;
  assign own_o         = own_q;
  assign bank_we_o     = we_q;
  assign bank_w_addr_o = w_addr_q;
  assign bank_w_dt_o   = w_dt_q;
  assign bank_rs_addr_o = rs_addr_q;

endmodule

// File: tb/tb_qcore_reg_dbg.sv
// tb/tb_qcore_reg_dbg.sv - self-checking bench for qcore_reg_dbg
module tb_qcore_reg_dbg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_ack = 1'b0;
  logic        stall_req;
  logic        own;
  logic        bank_we;
  logic [6:0]  bank_w_addr;
  logic [31:0] bank_w_dt;
  logic [6:0]  bank_rs_addr;
  logic [31:0] bank_rs_dt;

  int n_cmp = 0;
  int n_err = 0;

  int we_cnt = 0;
  int rd_cnt = 0;
  int stall_cyc = 0;
  int own_cyc = 0;

  logic [38:0] wq[$];
  logic [31:0] rq[$];

  qcore_reg_dbg_if #(.LEN_W(4)) hif ();

  qcore_reg_dbg #(
    .TOUT_W(4),
    .LEN_W (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .host           (hif),
    .stall_req_o    (stall_req),
    .stall_ack_i    (stall_ack),
    .own_o          (own),
    .bank_we_o      (bank_we),
    .bank_w_addr_o  (bank_w_addr),
    .bank_w_dt_o    (bank_w_dt),
    .bank_rs_addr_o (bank_rs_addr),
    .bank_rs_dt_i   (bank_rs_dt)
  );

  // Bank model: read data is the address.
  assign bank_rs_dt = {25'd0, bank_rs_addr};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  property p_ack_held;
    @(posedge clk) disable iff (!rst_n) (own && $past(stall_ack)) |-> stall_ack;
  endproperty
  a_ack_held: assert property (p_ack_held)
    else $error("FAIL stall_ack_protocol: stall_ack fell while owned");

  // Scoreboard side: compare every bank write and read word against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_req) stall_cyc++;
      if (own) own_cyc++;
      if (bank_we) begin
        logic [38:0] ew;
        we_cnt++;
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL sb_write: got addr %h data %h, required no write", bank_w_addr, bank_w_dt);
        end else begin
          ew = wq.pop_front();
          if ({bank_w_addr, bank_w_dt} !== ew) begin
            n_err++;
            $display("FAIL sb_write: got %h/%h, required %h/%h", bank_w_addr, bank_w_dt, ew[38:32], ew[31:0]);
          end
        end
      end
      if (hif.rd_vld_o) begin
        logic [31:0] er;
        rd_cnt++;
        n_cmp++;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL sb_read: got %h, required no word", hif.rd_dt_o);
        end else begin
          er = rq.pop_front();
          if (hif.rd_dt_o !== er) begin
            n_err++;
            $display("FAIL sb_read: got %h, required %h", hif.rd_dt_o, er);
          end
        end
      end
      n_cmp++;
      if (!own && ({bank_we, bank_w_addr, bank_w_dt, bank_rs_addr} !== 47'd0)) begin
        n_err++;
        $display("FAIL bank_idle: got we=%b wa=%h wd=%h ra=%h, required all 0", bank_we, bank_w_addr, bank_w_dt, bank_rs_addr);
      end
    end
  end

  function automatic logic [83:0] all_outs();
    return {hif.ack_o, hif.err_o, hif.rd_vld_o, hif.rd_dt_o, stall_req, own,
            bank_we, bank_w_addr, bank_w_dt, bank_rs_addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic op, input logic [6:0] addr, input logic [3:0] len,
                           input logic [31:0] wdt);
    hif.op_i   = op;
    hif.addr_i = addr;
    hif.len_i  = len;
    hif.wdt_i  = wdt;
    hif.req_i  = 1'b1;
  endtask

  // Counts edges from the first sampling edge of req until ack_o; -1 on expiry.
  task automatic wait_ack(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (hif.ack_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic release_req();
    hif.req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if (all_outs() !== 84'd0) begin
      n_err++;
      $display("FAIL reset_outs: got %h, required 0", all_outs());
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (all_outs() !== 84'd0) begin
      n_err++;
      $display("FAIL idle_outs: got %h, required 0", all_outs());
    end
  endtask

  task automatic test_write();
    int c;
    int we0;
    stall_ack = 1'b1;
    we0 = we_cnt;
    wq.push_back({7'h05, 32'hDEADBEEF});
    start_req(1'b1, 7'h05, 4'd0, 32'hDEADBEEF);
    tick();
    // Inputs change after capture and must be ignored.
    hif.op_i   = 1'b0;
    hif.addr_i = 7'h7F;
    hif.wdt_i  = 32'h0;
    wait_ack(20, c);
    if (c > 0) c = c + 1;
    n_cmp++;
    if (c !== 4) begin
      n_err++;
      $display("FAIL wr_latency: got %0d, required 4", c);
    end
    n_cmp++;
    if ({hif.err_o, stall_req, own} !== 3'b011) begin
      n_err++;
      $display("FAIL wr_done_flags: got err/stall/own=%b, required 011", {hif.err_o, stall_req, own});
    end
    release_req();
    n_cmp++;
    if ({hif.ack_o, hif.err_o, stall_req, own} !== 4'b0000) begin
      n_err++;
      $display("FAIL wr_release: got %b, required 0000", {hif.ack_o, hif.err_o, stall_req, own});
    end
    n_cmp++;
    if (we_cnt - we0 !== 1) begin
      n_err++;
      $display("FAIL wr_pulses: got %0d, required 1", we_cnt - we0);
    end
  endtask

  task automatic test_burst_read();
    int c;
    int r0;
    stall_ack = 1'b1;
    r0 = rd_cnt;
    rq.push_back(32'h3E);
    rq.push_back(32'h3F);
    rq.push_back(32'h00);
    rq.push_back(32'h01);
    start_req(1'b0, 7'h3E, 4'd3, 32'h0);
    wait_ack(40, c);
    n_cmp++;
    if (c !== 7) begin
      n_err++;
      $display("FAIL rd_latency: got %0d, required 7", c);
    end
    n_cmp++;
    if ({hif.rd_vld_o, hif.err_o} !== 2'b10) begin
      n_err++;
      $display("FAIL rd_last_ack: got vld/err=%b, required 10", {hif.rd_vld_o, hif.err_o});
    end
    release_req();
    n_cmp++;
    if ((rd_cnt - r0 !== 4) || (rq.size() !== 0)) begin
      n_err++;
      $display("FAIL rd_count: got %0d words, %0d left, required 4 and 0", rd_cnt - r0, rq.size());
    end
  endtask

  task automatic test_reject();
    int c;
    int s0;
    int o0;
    int w0;
    stall_ack = 1'b1;
    s0 = stall_cyc;
    o0 = own_cyc;
    w0 = we_cnt;
    start_req(1'b1, 7'h43, 4'd0, 32'h1234);
    wait_ack(10, c);
    n_cmp++;
    if ((c !== 2) || (hif.err_o !== 1'b1)) begin
      n_err++;
      $display("FAIL rej_sfr: got cyc %0d err %b, required 2 and 1", c, hif.err_o);
    end
    release_req();
    start_req(1'b0, 7'h60, 4'd0, 32'h0);
    wait_ack(10, c);
    n_cmp++;
    if ((c !== 2) || (hif.err_o !== 1'b1)) begin
      n_err++;
      $display("FAIL rej_page3: got cyc %0d err %b, required 2 and 1", c, hif.err_o);
    end
    release_req();
    n_cmp++;
    if ((stall_cyc != s0) || (own_cyc != o0) || (we_cnt != w0)) begin
      n_err++;
      $display("FAIL rej_no_access: got stall %0d own %0d we %0d cycles, required 0",
               stall_cyc - s0, own_cyc - o0, we_cnt - w0);
    end
  endtask

  task automatic test_timeout();
    int c;
    int s0;
    int o0;
    int w0;
    stall_ack = 1'b0;
    s0 = stall_cyc;
    o0 = own_cyc;
    w0 = we_cnt;
    start_req(1'b1, 7'h05, 4'd0, 32'hAAAA5555);
    wait_ack(40, c);
    n_cmp++;
    if ((c !== 17) || (hif.err_o !== 1'b1)) begin
      n_err++;
      $display("FAIL tout_ack: got cyc %0d err %b, required 17 and 1", c, hif.err_o);
    end
    n_cmp++;
    if (stall_cyc - s0 !== 15) begin
      n_err++;
      $display("FAIL tout_stall_cycles: got %0d, required 15", stall_cyc - s0);
    end
    n_cmp++;
    if ((own_cyc != o0) || (we_cnt != w0)) begin
      n_err++;
      $display("FAIL tout_no_access: got own %0d we %0d, required 0", own_cyc - o0, we_cnt - w0);
    end
    release_req();
  endtask

  task automatic test_delayed_ack();
    int c;
    int w0;
    stall_ack = 1'b0;
    w0 = we_cnt;
    wq.push_back({7'h42, 32'h12345678});
    start_req(1'b1, 7'h42, 4'd0, 32'h12345678);
    c = 0;
    while (!stall_req && c < 10) begin
      tick();
      c++;
    end
    repeat (7) tick();
    n_cmp++;
    if (own !== 1'b0) begin
      n_err++;
      $display("FAIL dly_own_early: got %b, required 0", own);
    end
    stall_ack = 1'b1;
    tick();
    n_cmp++;
    if ({own, bank_we} !== 2'b11) begin
      n_err++;
      $display("FAIL dly_own_we: got own/we=%b, required 11", {own, bank_we});
    end
    tick();
    n_cmp++;
    if ({hif.ack_o, hif.err_o, bank_we} !== 3'b100) begin
      n_err++;
      $display("FAIL dly_done: got ack/err/we=%b, required 100", {hif.ack_o, hif.err_o, bank_we});
    end
    release_req();
    stall_ack = 1'b0;
    n_cmp++;
    if (we_cnt - w0 !== 1) begin
      n_err++;
      $display("FAIL dly_pulses: got %0d, required 1", we_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_read();
    int c;
    int r0;
    int w0;
    stall_ack = 1'b1;
    r0 = rd_cnt;
    for (int i = 0; i < 16; i++) rq.push_back(32'h10 + i);
    start_req(1'b0, 7'h10, 4'd15, 32'h0);
    c = 0;
    while ((rd_cnt - r0 < 3) && c < 20) begin
      tick();
      c++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== 84'd0) begin
      n_err++;
      $display("FAIL rst_mid_outs: got %h, required 0", all_outs());
    end
    rq.delete();
    hif.req_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    w0 = we_cnt;
    wq.push_back({7'h07, 32'hCAFEF00D});
    start_req(1'b1, 7'h07, 4'd0, 32'hCAFEF00D);
    wait_ack(20, c);
    n_cmp++;
    if ((c !== 4) || (hif.err_o !== 1'b0)) begin
      n_err++;
      $display("FAIL rst_fresh_wr: got cyc %0d err %b, required 4 and 0", c, hif.err_o);
    end
    release_req();
    n_cmp++;
    if (we_cnt - w0 !== 1) begin
      n_err++;
      $display("FAIL rst_fresh_pulses: got %0d, required 1", we_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int w0;
    stall_ack = 1'b1;
    w0 = we_cnt;
    wq.push_back({7'h01, 32'h11111111});
    wq.push_back({7'h22, 32'h22222222});
    start_req(1'b1, 7'h01, 4'd0, 32'h11111111);
    wait_ack(20, c);
    release_req();
    n_cmp++;
    if (hif.ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap_ack: got %b, required 0", hif.ack_o);
    end
    start_req(1'b1, 7'h22, 4'd0, 32'h22222222);
    wait_ack(20, c);
    n_cmp++;
    if ((c !== 4) || (hif.err_o !== 1'b0)) begin
      n_err++;
      $display("FAIL b2b_second: got cyc %0d err %b, required 4 and 0", c, hif.err_o);
    end
    release_req();
    n_cmp++;
    if ((we_cnt - w0 !== 2) || (wq.size() !== 0)) begin
      n_err++;
      $display("FAIL b2b_writes: got %0d pulses, %0d pending, required 2 and 0", we_cnt - w0, wq.size());
    end
  endtask

  initial begin
    hif.req_i  = 1'b0;
    hif.op_i   = 1'b0;
    hif.addr_i = '0;
    hif.len_i  = '0;
    hif.wdt_i  = '0;
    test_reset();
    test_write();
    test_burst_read();
    test_reject();
    test_timeout();
    test_delayed_ack();
    test_reset_mid_read();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
